// File: rtl/imm_pkg.sv
// Shared immediate-type codes, RV opcodes and the opcode-to-type decoder.
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'd0;
  localparam logic [2:0] IMM_S   = 3'd1;
  localparam logic [2:0] IMM_B   = 3'd2;
  localparam logic [2:0] IMM_J   = 3'd3;
  localparam logic [2:0] IMM_U   = 3'd4;
  localparam logic [2:0] IMM_Z   = 3'd5;
  localparam logic [2:0] IMM_BAD = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // funct3[2] separates CSR-immediate forms (uimm in rs1) from register forms.
  function automatic logic [2:0] decode_type(input logic [6:0] opcode, input logic funct3_2);
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: return IMM_I;
      OP_STORE:                           return IMM_S;
      OP_BRANCH:                          return IMM_B;
      OP_JAL:                             return IMM_J;
      OP_LUI, OP_AUIPC:                   return IMM_U;
      OP_SYSTEM:                          return funct3_2 ? IMM_Z : IMM_I;
      default:                            return IMM_BAD;
    endcase
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: instruction and type code to XLEN-wide immediate.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (imm_type)
      IMM_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      IMM_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      IMM_U: imm32 = {instruction[31:12], 12'b0};
      IMM_Z: imm32 = {27'b0, instruction[19:15]};
      default: illegal = 1'b1;
    endcase
  end

  // Every 32-bit form is already correctly signed, so widening replicates bit 31.
  if (XLEN > 32) begin : g_wide
    assign imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign imm = imm32;
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a 2-entry output FIFO; extends at acceptance, 1-cycle latency.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic             imm_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [2:0]      imm_type;
  logic [XLEN-1:0] core_imm;
  logic            core_illegal;

  assign imm_type = AUTO_DECODE ? decode_type(instruction[6:0], instruction[14]) : imm_src;

  imm_ext_core #(
    .XLEN(XLEN)
  ) u_core (
    .instruction(instruction),
    .imm_type   (imm_type),
    .imm        (core_imm),
    .illegal    (core_illegal)
  );

  logic [XLEN-1:0]  mem_imm [2];
  logic             mem_ill [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // A pop frees a slot in the same cycle, so a full buffer still accepts when draining.
  assign in_ready  = (count < 2'd2) || out_ready;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_imm[i] <= '0;
        mem_ill[i] <= 1'b0;
        mem_tag[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= core_imm;
        mem_ill[wr_ptr] <= core_illegal;
        mem_tag[wr_ptr] <= in_tag;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

  assign imm_ext     = out_valid ? mem_imm[rd_ptr] : '0;
  assign imm_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;
  assign out_tag     = out_valid ? mem_tag[rd_ptr] : '0;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Three configurations share one stimulus stream and are checked against a queue-based model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [31:0] imm0, imm1;
  logic [63:0] imm2;
  logic        ill0, ill1, ill2;
  logic [4:0]  tag0, tag1, tag2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(5)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .instruction(instruction), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .imm_ext(imm0),
    .imm_illegal(ill0), .out_tag(tag0)
  );

  imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .TAG_W(5)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .instruction(instruction), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .imm_ext(imm1),
    .imm_illegal(ill1), .out_tag(tag1)
  );

  imm_ext_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(5)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .instruction(instruction), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .imm_ext(imm2),
    .imm_illegal(ill2), .out_tag(tag2)
  );

  typedef struct {
    logic [63:0] i0, i1, i2;
    logic        l0, l1, l2;
    logic [4:0]  tag;
  } ent_t;

  ent_t       q[$];
  logic [4:0] delivered[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Type codes straight from the opcode table; 6 means unsupported.
  function automatic int auto_type(input logic [31:0] ins);
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: return 0;
      7'b0100011: return 1;
      7'b1100011: return 2;
      7'b1101111: return 3;
      7'b0110111, 7'b0010111: return 4;
      7'b1110011: return ins[14] ? 5 : 0;
      default: return 6;
    endcase
  endfunction

  task automatic ref_imm(input logic [31:0] ins, input int t, input int xlen,
                         output logic [63:0] v, output logic ill);
    longint s;
    ill = 1'b0;
    case (t)
      0: s = longint'($signed(ins[31:20]));
      1: s = longint'($signed({ins[31:25], ins[11:7]}));
      2: s = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3: s = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      4: s = longint'($signed({ins[31:12], 12'b0}));
      5: s = longint'(ins[19:15]);
      default: begin s = 0; ill = 1'b1; end
    endcase
    v = (xlen == 32) ? {32'b0, s[31:0]} : s;
  endtask

  task automatic compute_entry(output ent_t e);
    int t;
    ref_imm(instruction, int'(imm_src), 32, e.i0, e.l0);
    t = auto_type(instruction);
    ref_imm(instruction, t, 32, e.i1, e.l1);
    ref_imm(instruction, t, 64, e.i2, e.l2);
    e.tag = in_tag;
  endtask

  task automatic check_all();
    logic ev, er;
    ev = (q.size() != 0);
    er = (q.size() < 2) || out_ready;
    chk("out_valid0", 64'(out_valid0), 64'(ev));
    chk("out_valid1", 64'(out_valid1), 64'(ev));
    chk("out_valid2", 64'(out_valid2), 64'(ev));
    chk("in_ready0", 64'(in_ready0), 64'(er));
    chk("in_ready1", 64'(in_ready1), 64'(er));
    chk("in_ready2", 64'(in_ready2), 64'(er));
    if (ev) begin
      chk("imm0", 64'(imm0), q[0].i0);
      chk("imm1", 64'(imm1), q[0].i1);
      chk("imm2", imm2, q[0].i2);
      chk("ill0", 64'(ill0), 64'(q[0].l0));
      chk("ill1", 64'(ill1), 64'(q[0].l1));
      chk("ill2", 64'(ill2), 64'(q[0].l2));
      chk("tag0", 64'(tag0), 64'(q[0].tag));
      chk("tag1", 64'(tag1), 64'(q[0].tag));
      chk("tag2", 64'(tag2), 64'(q[0].tag));
    end else begin
      chk("empty_out0", {31'b0, ill0, tag0, imm0}, 64'd0);
      chk("empty_out1", {31'b0, ill1, tag1, imm1}, 64'd0);
      chk("empty_out2", {59'b0, ill2, tag2} | imm2, 64'd0);
    end
  endtask

  // One clock: decide transfers from the model, advance both, compare on the falling edge.
  task automatic step();
    logic push, pop;
    ent_t e;
    push = in_valid && ((q.size() < 2) || out_ready);
    pop  = (q.size() != 0) && out_ready;
    if (push) compute_entry(e);
    @(posedge clk);
    if (pop) begin
      delivered.push_back(q[0].tag);
      void'(q.pop_front());
    end
    if (push) q.push_back(e);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tg);
    instruction = ins;
    imm_src     = src;
    in_tag      = tg;
    in_valid    = 1'b1;
  endtask

  initial begin
    logic [63:0] v;
    logic        il;
    logic [6:0]  ops[10];
    logic [31:0] ins;
    ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011};

    // Pin the reference model against hand-computed values.
    ref_imm(32'hFFF00093, 0, 32, v, il);           chk("model_i", v, 64'hFFFFFFFF);
    ref_imm(32'hFE20AE23, 1, 32, v, il);           chk("model_s", v, 64'hFFFFFFFC);
    ref_imm(32'h0080006F, auto_type(32'h0080006F), 32, v, il); chk("model_j", v, 64'h8);
    ref_imm(32'h800000B7, auto_type(32'h800000B7), 64, v, il);
    chk("model_u64", v, 64'hFFFFFFFF80000000);
    ref_imm(32'h0000007F, auto_type(32'h0000007F), 32, v, il);
    chk("model_bad", {v[62:0], il}, 64'd1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0; imm_src = '0; in_tag = '0;
    @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // Directed vectors, each observed one cycle after acceptance.
    drive(32'hFFF00093, 3'd0, 5'd1); step(); chk("i_type", 64'(imm0), 64'hFFFFFFFF);
    drive(32'hFE20AE23, 3'd1, 5'd2); step(); chk("s_type", 64'(imm0), 64'hFFFFFFFC);
    drive(32'h0080006F, 3'd7, 5'd3); step(); chk("auto_jal", 64'(imm1), 64'h8);
    drive(32'h123450B7, 3'd6, 5'd4); step(); chk("auto_lui", 64'(imm1), 64'h12345000);
    drive(32'h0000007F, 3'd0, 5'd5); step();
    chk("auto_bad", {31'b0, ill1, imm1}, 64'h1_0000_0000);
    drive(32'h800000B7, 3'd4, 5'd6); step(); chk("lui_64", imm2, 64'hFFFFFFFF80000000);
    in_valid = 1'b0; step();

    // Backpressure: third push must stall until the consumer drains.
    delivered.delete();
    out_ready = 1'b0;
    drive(32'h00100093, 3'd0, 5'd1); step();
    drive(32'h00200093, 3'd0, 5'd2); step();
    chk("bp_full_ready", {in_ready0, in_ready1, in_ready2}, 64'd0);
    drive(32'h00300093, 3'd0, 5'd3); step(); step();
    chk("bp_hold_tag", 64'(tag0), 64'd1);
    out_ready = 1'b1; step();
    in_valid = 1'b0; step(); step(); step();
    chk("bp_count", 64'(delivered.size()), 64'd3);
    if (delivered.size() == 3) begin
      chk("bp_order", {delivered[0], delivered[1], delivered[2]}, {5'd1, 5'd2, 5'd3});
    end

    // Steady push+pop at one entry.
    drive(32'h00A00093, 3'd0, 5'd10); step();
    for (int i = 0; i < 10; i++) begin
      drive(32'h00B00093 + 32'(i << 20), 3'd0, 5'(11 + i)); step();
      chk("pp_valid", 64'(out_valid0), 64'd1);
      chk("pp_tag", 64'(tag0), 64'(11 + i));
    end
    in_valid = 1'b0; step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 9)];
      instruction = ins;
      imm_src     = 3'($urandom_range(0, 7));
      in_tag      = 5'($urandom);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
    end

    // Asynchronous reset with a full buffer, between edges.
    out_ready = 1'b0;
    drive(32'h00100093, 3'd0, 5'd7); step();
    drive(32'h00200093, 3'd0, 5'd8); step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("rst_valid", {out_valid0, out_valid1, out_valid2}, 64'd0);
    chk("rst_outs", {27'b0, ill0, tag0, imm0} | imm2, 64'd0);
    chk("rst_ready", {in_ready0, in_ready1, in_ready2}, 64'h7);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    drive(32'hFFF00093, 3'd0, 5'd9); step();
    chk("post_rst_imm", 64'(imm0), 64'hFFFFFFFF);
    chk("post_rst_tag", 64'(tag0), 64'd9);
    in_valid = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
